dm_responder: RTL and testbench

Data-memory responder for the pipelined core's M-stage data port (`m_data_*`). It provides zero-wait-state combinational reads and byte-enable writes on the clock edge. Every accepted store is logged into a small trace FIFO, which a testbench or debug unit drains through a valid/ready handshake. The block sits outside the core, at the far end of `m_data_addr`/`m_data_wdata`/`m_data_byteen`/`m_data_rdata`.

---
 rtl/dm_responder_pkg.sv | 40 ++++
 rtl/dm_responder_trace_fifo.sv | 66 ++++++
 rtl/dm_responder.sv | 110 +++++++++++
 tb/tb_dm_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: byte-enable encodings,
// trace entry layout and the byte-lane merge used for both memory and trace.
package dm_responder_pkg;

    typedef enum logic [3:0] {
        BE_NONE = 4'b0000,
        BE_B0   = 4'b0001,
        BE_B1   = 4'b0010,
        BE_H0   = 4'b0011,
        BE_B2   = 4'b0100,
        BE_B3   = 4'b1000,
        BE_H1   = 4'b1100,
        BE_W    = 4'b1111
    } byteen_e;

    localparam int unsigned TR_PC_W   = 32;
    localparam int unsigned TR_ADDR_W = 32;
    localparam int unsigned TR_DATA_W = 32;
    localparam int unsigned TR_BE_W   = 4;
    localparam int unsigned TRACE_W   = TR_PC_W + TR_ADDR_W + TR_DATA_W + TR_BE_W;

    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_ADDR_W-1:0] addr;
        logic [TR_DATA_W-1:0] data;
        logic [TR_BE_W-1:0]   byteen;
    } trace_entry_t;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] res;
        res = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Synchronous FIFO holding store trace entries; head output is zero when empty
// and is driven straight from storage, so a push is visible only after the edge.
module trace_fifo #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the core's M-stage data port: combinational reads,
// byte-enable writes, and a trace FIFO logging every in-range store.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [3:0]  trace_byteen,
    output logic        overflow,
    output logic        addr_err
);

    localparam int unsigned MEM_WORDS = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q [MEM_WORDS];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  wr_en;
    logic [31:0]           old_word;
    logic [31:0]           merged_word;
    trace_entry_t          push_entry;
    trace_entry_t          head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [$clog2(TRACE_DEPTH):0] unused_count;
    logic                  unused_addr_lsb;
    logic                  overflow_q, overflow_d;
    logic                  addr_err_q, addr_err_d;

    assign word_idx        = m_data_addr[ADDR_WIDTH+1:2];
    assign in_range        = (m_data_addr[31:ADDR_WIDTH+2] == '0);
    assign wr_en           = in_range && (m_data_byteen != BE_NONE);
    assign old_word        = mem_q[word_idx];
    assign merged_word     = merge_word(old_word, m_data_wdata, m_data_byteen);
    assign unused_addr_lsb = ^m_data_addr[1:0];

    assign m_data_rdata = in_range ? old_word : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = m_inst_addr;
        push_entry.addr   = {m_data_addr[31:2], 2'b00};
        push_entry.data   = merged_word;
        push_entry.byteen = m_data_byteen;
    end

    assign fifo_pop = trace_valid && trace_ready;

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (wr_en),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_count)
    );

    assign trace_valid  = !fifo_empty;
    assign trace_pc     = head_entry.pc;
    assign trace_addr   = head_entry.addr;
    assign trace_data   = head_entry.data;
    assign trace_byteen = head_entry.byteen;

    always_comb begin
        overflow_d = overflow_q || (wr_en && fifo_full && !fifo_pop);
        addr_err_d = addr_err_q || !in_range;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign overflow = overflow_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with a memory model and a trace scoreboard.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_byteen;
    logic        overflow;
    logic        addr_err;
    logic [99:0] head_obs;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [4096];
    logic [99:0] sb_q [$];
    logic        exp_ovf;
    logic        exp_aerr;

    dm_responder #(
        .ADDR_WIDTH  (12),
        .TRACE_DEPTH (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_byteen  (trace_byteen),
        .overflow      (overflow),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    assign head_obs = {trace_pc, trace_addr, trace_data, trace_byteen};

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        foreach (mem_m[i]) mem_m[i] = '0;
        sb_q.delete();
        exp_ovf  = 1'b0;
        exp_aerr = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:14] == 18'd0) return mem_m[a[13:2]];
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (wd & mask);
    endfunction

    // One clock of stimulus: drive at negedge, check combinational outputs,
    // update the model, then check sticky flags after the edge.
    task automatic cycle(input logic [31:0] pc, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic rdy);
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [99:0] popped;
        bit          pop;
        @(negedge clk);
        m_inst_addr   = pc;
        m_data_addr   = a;
        m_data_byteen = be;
        m_data_wdata  = wd;
        trace_ready   = rdy;
        #1;
        old_w = model_read(a);
        chk("rdata", m_data_rdata, old_w);
        if (sb_q.size() > 0) begin
            chk("trace_valid", trace_valid, 1'b1);
            chk("trace_head", head_obs, sb_q[0]);
        end else begin
            chk("trace_valid_empty", trace_valid, 1'b0);
            chk("trace_head_empty", head_obs, 100'd0);
        end
        pop = rdy && (sb_q.size() > 0);
        if (pop) popped = sb_q.pop_front();
        if (a[31:14] != 18'd0) begin
            exp_aerr = 1'b1;
        end else if (be != 4'b0000) begin
            new_w = model_merge(old_w, wd, be);
            mem_m[a[13:2]] = new_w;
            if (sb_q.size() < 8) sb_q.push_back({pc, a[31:2], 2'b00, new_w, be});
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("overflow", overflow, exp_ovf);
        chk("addr_err", addr_err, exp_aerr);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) cycle(32'h200, 32'h10, 4'b0000, 32'h0, 1'b1);
        cycle(32'h204, 32'h10, 4'b0000, 32'h0, 1'b1);
    endtask

    initial begin
        reset         = 1'b0;
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        m_inst_addr   = '0;
        trace_ready   = 1'b0;
        clear_model();
        #12;
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_head", head_obs, 100'd0);
        chk("rst_rdata", m_data_rdata, 32'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // word store, read back, byte store, read-during-write, halfword store
        cycle(32'h100, 32'h10, 4'b1111, 32'h1234_5678, 1'b0);
        cycle(32'h104, 32'h10, 4'b0000, 32'h0, 1'b0);
        cycle(32'h108, 32'h13, 4'b1000, 32'hABAB_ABAB, 1'b1);
        cycle(32'h10C, 32'h10, 4'b0000, 32'h0, 1'b1);
        cycle(32'h110, 32'h20, 4'b1111, 32'hFFFF_FFFF, 1'b0);
        cycle(32'h114, 32'h20, 4'b0000, 32'h0, 1'b1);
        cycle(32'h118, 32'h22, 4'b1100, 32'h1234_1234, 1'b1);
        cycle(32'h11C, 32'h24, 4'b0001, 32'h5A5A_5A5A, 1'b1);
        drain();

        // fill beyond capacity, then push with a simultaneous pop
        for (int k = 0; k < 9; k++)
            cycle(32'h300 + 32'(4 * k), 32'h40 + 32'(4 * k), 4'b1111, $urandom, 1'b0);
        cycle(32'h400, 32'h80, 4'b1111, 32'hCAFE_F00D, 1'b1);
        drain();

        // out-of-range store must not alias onto word 0
        cycle(32'h500, 32'h0001_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        cycle(32'h504, 32'h0000_0000, 4'b0000, 32'h0, 1'b0);

        // async reset with queued entries
        cycle(32'h600, 32'h10, 4'b1111, 32'h1111_1111, 1'b0);
        cycle(32'h604, 32'h14, 4'b1111, 32'h2222_2222, 1'b0);
        cycle(32'h608, 32'h18, 4'b1111, 32'h3333_3333, 1'b0);
        #2;
        reset         = 1'b0;
        m_data_byteen = 4'b0000;
        m_data_addr   = 32'h10;
        #1;
        chk("arst_valid", trace_valid, 1'b0);
        chk("arst_head", head_obs, 100'd0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_addr_err", addr_err, 1'b0);
        chk("arst_rdata", m_data_rdata, 32'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        cycle(32'h700, 32'h10, 4'b0000, 32'h0, 1'b1);
        cycle(32'h704, 32'h18, 4'b0011, 32'h7777_7777, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
